// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty fetch stage: FSM states, bus register
// offsets and CTRL bit positions.
package bitty_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_HALT
   } state_t;

   // Byte offsets; the bus decodes only adr[6:2]
   localparam logic [6:0] OFF_CTRL   = 7'h00;
   localparam logic [6:0] OFF_STATUS = 7'h04;
   localparam logic [6:0] OFF_LEN    = 7'h08;
   localparam logic [6:0] OFF_IMEM   = 7'h40;

   localparam int CTRL_START = 0;
   localparam int CTRL_STOP  = 1;

endpackage

// File: rtl/bitty_imem.sv
// Instruction buffer: DEPTH x BITS register file, one write port and two
// asynchronous read ports (fetch side and bus side).
module bitty_imem #(
   parameter  int BITS  = 16,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [BITS-1:0] i_wdata,
   input  logic [AW-1:0]   i_fetchAddr,
   output logic [BITS-1:0] o_fetchData,
   input  logic [AW-1:0]   i_busAddr,
   output logic [BITS-1:0] o_busData
);

   logic [BITS-1:0] r_mem [DEPTH];

   // Contents are deliberately left unreset; the host loads them before start
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_fetchData = r_mem[i_fetchAddr];
   assign o_busData   = r_mem[i_busAddr];

endmodule

// File: rtl/bitty_fetch.sv
// Fetch/sequencing stage for the bitty core: Wishbone-loaded instruction
// buffer, LEN/CTRL/STATUS registers and the run/done issue FSM.
module bitty_fetch
   import bitty_pkg::*;
#(
   parameter  int BITS  = 16,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wbs_stb_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   output logic [BITS-1:0] instr,
   output logic            run,
   input  logic            done,
   output logic [AW-1:0]   pc,
   output logic            busy,
   output logic            irq
);

   localparam int LW = AW + 1;

   state_t          r_state;
   state_t          w_nextState;
   logic [AW-1:0]   r_pc;
   logic [LW-1:0]   r_len;
   logic            r_halted;
   logic            r_irq;
   logic            r_stopPend;
   logic            r_startReq;
   logic            r_stopReq;
   logic            r_ack;
   logic [31:0]     r_datO;
   logic [BITS-1:0] r_instr;

   logic            w_valid;
   logic            w_wrOk;
   logic [4:0]      w_word;
   logic [4:0]      w_imemOff;
   logic            w_isCtrl;
   logic            w_isStatus;
   logic            w_isLen;
   logic            w_isImem;
   logic [BITS-1:0] w_lenIn;
   logic [LW-1:0]   w_lenSat;
   logic [31:0]     w_rdata;
   logic [BITS-1:0] w_fetch;
   logic [BITS-1:0] w_busRd;
   logic            w_issue;
   logic            w_busy;
   logic            w_last;
   logic            w_loadPc;
   logic            w_incPc;
   logic            w_setHalt;
   logic            w_unused;

   assign w_valid    = wbs_cyc_i & wbs_stb_i & ~r_ack;
   assign w_wrOk     = w_valid & wbs_we_i & (wbs_sel_i[1:0] == 2'b11);
   assign w_word     = wbs_adr_i[6:2];
   assign w_imemOff  = w_word - OFF_IMEM[6:2];
   assign w_isCtrl   = (w_word == OFF_CTRL[6:2]);
   assign w_isStatus = (w_word == OFF_STATUS[6:2]);
   assign w_isLen    = (w_word == OFF_LEN[6:2]);
   assign w_isImem   = (w_word >= OFF_IMEM[6:2]) && (w_imemOff < 5'(DEPTH));

   // A zero or oversize length would never match pc, so it is clamped to a full buffer
   assign w_lenIn  = wbs_dat_i[BITS-1:0];
   assign w_lenSat = ((w_lenIn == '0) || (w_lenIn > BITS'(DEPTH))) ? LW'(DEPTH) : w_lenIn[LW-1:0];

   assign w_issue = (r_state == ST_ISSUE);
   assign w_busy  = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
   assign w_last  = ({1'b0, r_pc} == (r_len - LW'(1)));

   bitty_imem #(
      .BITS  (BITS),
      .DEPTH (DEPTH)
   ) u_imem (
      .clk         (clk),
      .i_we        (w_wrOk & w_isImem & ~w_busy),
      .i_waddr     (w_imemOff[AW-1:0]),
      .i_wdata     (wbs_dat_i[BITS-1:0]),
      .i_fetchAddr (r_pc),
      .o_fetchData (w_fetch),
      .i_busAddr   (w_imemOff[AW-1:0]),
      .o_busData   (w_busRd)
   );

   always_comb begin
      w_rdata = '0;
      if (w_isStatus) begin
         w_rdata[0]       = w_busy;
         w_rdata[1]       = r_halted;
         w_rdata[8 +: AW] = r_pc;
      end else if (w_isLen) begin
         w_rdata[LW-1:0] = r_len;
      end else if (w_isImem) begin
         w_rdata[BITS-1:0] = w_busRd;
      end
   end

   // CTRL writes become one-cycle requests seen by the FSM the cycle ack is high
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ack      <= 1'b0;
         r_datO     <= '0;
         r_len      <= LW'(DEPTH);
         r_startReq <= 1'b0;
         r_stopReq  <= 1'b0;
      end else begin
         r_ack      <= w_valid;
         r_startReq <= w_wrOk & w_isCtrl & wbs_dat_i[CTRL_START] & ~wbs_dat_i[CTRL_STOP];
         r_stopReq  <= w_wrOk & w_isCtrl & wbs_dat_i[CTRL_STOP];
         if (w_valid & ~wbs_we_i) begin
            r_datO <= w_rdata;
         end
         if (w_wrOk & w_isLen) begin
            r_len <= w_lenSat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_loadPc    = 1'b0;
      w_incPc     = 1'b0;
      w_setHalt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_startReq) begin
               w_nextState = ST_ISSUE;
               w_loadPc    = 1'b1;
            end
         end
         ST_ISSUE: begin
            w_nextState = r_stopReq ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (done) begin
               if (r_stopPend | r_stopReq) begin
                  w_nextState = ST_IDLE;
               end else if (w_last) begin
                  w_nextState = ST_HALT;
                  w_setHalt   = 1'b1;
               end else begin
                  w_nextState = ST_ISSUE;
                  w_incPc     = 1'b1;
               end
            end
         end
         ST_HALT: begin
            if (r_stopReq) begin
               w_nextState = ST_IDLE;
            end else if (r_startReq) begin
               w_nextState = ST_ISSUE;
               w_loadPc    = 1'b1;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // A stop seen during WAIT is held until the core reports done
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc       <= '0;
         r_halted   <= 1'b0;
         r_irq      <= 1'b0;
         r_stopPend <= 1'b0;
         r_instr    <= '0;
      end else begin
         if (w_loadPc) begin
            r_pc <= '0;
         end else if (w_incPc) begin
            r_pc <= r_pc + AW'(1);
         end
         if (w_loadPc) begin
            r_halted <= 1'b0;
         end else if (w_setHalt) begin
            r_halted <= 1'b1;
         end
         r_irq      <= w_setHalt;
         r_stopPend <= ((r_state == ST_WAIT) && (w_nextState == ST_WAIT)) ? (r_stopPend | r_stopReq) : 1'b0;
         if (w_issue) begin
            r_instr <= w_fetch;
         end
      end
   end

   assign instr     = w_issue ? w_fetch : r_instr;
   assign run       = w_issue;
   assign busy      = w_busy;
   assign pc        = r_pc;
   assign irq       = r_irq;
   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_datO;

   assign w_unused = &{1'b0, wbs_adr_i[31:7], wbs_adr_i[1:0], wbs_sel_i[3:2],
                       wbs_dat_i[31:BITS], w_imemOff[4:AW]};

endmodule

// File: tb/tb_bitty_fetch.sv
// Directed bench for bitty_fetch: Wishbone host tasks, a fixed-latency core
// model and a run/irq monitor, with hand-computed expected values.
module tb_bitty_fetch;

   localparam int BITS  = 16;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   localparam logic [31:0] A_CTRL   = 32'h00;
   localparam logic [31:0] A_STATUS = 32'h04;
   localparam logic [31:0] A_LEN    = 32'h08;
   localparam logic [31:0] A_IMEM   = 32'h40;

   logic            clk;
   logic            reset;
   logic            wbs_stb_i;
   logic            wbs_cyc_i;
   logic            wbs_we_i;
   logic [3:0]      wbs_sel_i;
   logic [31:0]     wbs_adr_i;
   logic [31:0]     wbs_dat_i;
   logic            wbs_ack_o;
   logic [31:0]     wbs_dat_o;
   logic [BITS-1:0] instr;
   logic            run;
   logic            done;
   logic [AW-1:0]   pc;
   logic            busy;
   logic            irq;

   int errorCount = 0;
   int checkCount = 0;
   int runCount   = 0;
   int irqCount   = 0;
   int doneCnt    = 0;
   logic coreEnable = 1'b0;
   logic [BITS-1:0] instrLog[$];
   logic [BITS-1:0] expInstr [3] = '{16'h1111, 16'h2222, 16'h3333};

   bitty_fetch #(
      .BITS  (BITS),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wbs_stb_i (wbs_stb_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .instr     (instr),
      .run       (run),
      .done      (done),
      .pc        (pc),
      .busy      (busy),
      .irq       (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor run/irq pulses on the falling edge, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (run) begin
            runCount++;
            instrLog.push_back(instr);
            if (coreEnable) doneCnt = 3;
         end
         if (irq) irqCount++;
      end
   end

   // Core model: done pulses three cycles after each run
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (coreEnable) begin
            done = 1'b0;
            if (doneCnt > 0) begin
               doneCnt--;
               if (doneCnt == 0) done = 1'b1;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic waitAck();
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!wbs_ack_o && n < 20);
      if (!wbs_ack_o) checkOutput("ackTimeout", {31'b0, wbs_ack_o}, 32'h1);
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
      wbs_adr_i = addr;
      wbs_dat_i = data;
      wbs_sel_i = sel;
      wbs_we_i  = 1'b1;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      waitAck();
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
   endtask

   task automatic wbRead(input logic [31:0] addr, output logic [31:0] data);
      wbs_adr_i = addr;
      wbs_sel_i = 4'hF;
      wbs_we_i  = 1'b0;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      waitAck();
      data = wbs_dat_o;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
   endtask

   task automatic clearMonitor();
      runCount = 0;
      irqCount = 0;
      instrLog.delete();
   endtask

   initial begin
      logic [31:0] rd;
      bit found;
      reset = 1'b1;
      done = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0;
      wbs_adr_i = '0;
      wbs_dat_i = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] reset state");
      checkOutput("rstRun", {31'b0, run}, 32'h0);
      checkOutput("rstIrq", {31'b0, irq}, 32'h0);
      checkOutput("rstBusy", {31'b0, busy}, 32'h0);
      checkOutput("rstPc", {28'b0, pc}, 32'h0);
      checkOutput("rstInstr", {16'b0, instr}, 32'h0);
      checkOutput("rstAck", {31'b0, wbs_ack_o}, 32'h0);
      checkOutput("rstDat", wbs_dat_o, 32'h0);
      wbRead(A_STATUS, rd);
      checkOutput("rstStatus", rd, 32'h0);
      wbRead(A_LEN, rd);
      checkOutput("rstLen", rd, 32'd16);

      $display("[TB] three-instruction program");
      applyStimulus(A_IMEM + 32'h0, 32'h1111, 4'hF);
      applyStimulus(A_IMEM + 32'h4, 32'h2222, 4'hF);
      applyStimulus(A_IMEM + 32'h8, 32'h3333, 4'hF);
      applyStimulus(A_LEN, 32'd3, 4'hF);
      wbRead(A_LEN, rd);
      checkOutput("len3", rd, 32'd3);
      clearMonitor();
      coreEnable = 1'b1;
      applyStimulus(A_CTRL, 32'h1, 4'hF);
      @(posedge clk);
      #1;
      checkOutput("startLatencyRun", {31'b0, run}, 32'h1);
      checkOutput("firstInstr", {16'b0, instr}, 32'h1111);
      checkOutput("busyRunning", {31'b0, busy}, 32'h1);
      applyStimulus(A_IMEM + 32'h4, 32'hBEEF, 4'hF);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk);
         #1;
         if (irqCount > 0) found = 1'b1;
      end
      if (!found) checkOutput("irqTimeout", 32'h0, 32'h1);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("runCount3", runCount, 32'd3);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("instr%0d", i),
                     (i < instrLog.size()) ? {16'b0, instrLog[i]} : 32'hDEAD0000,
                     {16'b0, expInstr[i]});
      end
      checkOutput("irqOnce", irqCount, 32'd1);
      wbRead(A_STATUS, rd);
      checkOutput("statusHalt", rd, 32'h0202);
      wbRead(A_IMEM + 32'h4, rd);
      checkOutput("busyWriteDropped", rd, 32'h2222);
      applyStimulus(A_IMEM + 32'h8, 32'hAAAA, 4'b0001);
      wbRead(A_IMEM + 32'h8, rd);
      checkOutput("selWriteDropped", rd, 32'h3333);
      wbRead(32'h0C, rd);
      checkOutput("unmappedRead", rd, 32'h0);
      wbRead(A_CTRL, rd);
      checkOutput("ctrlReadZero", rd, 32'h0);

      $display("[TB] stop during WAIT");
      clearMonitor();
      applyStimulus(A_CTRL, 32'h1, 4'hF);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (run && pc == AW'(1)) found = 1'b1;
      end
      if (!found) checkOutput("stopSetupTimeout", 32'h0, 32'h1);
      @(posedge clk);
      #1;
      applyStimulus(A_CTRL, 32'h2, 4'hF);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("stopBusy", {31'b0, busy}, 32'h0);
      checkOutput("stopPc", {28'b0, pc}, 32'h1);
      checkOutput("stopIrq", irqCount, 32'h0);
      checkOutput("stopRuns", runCount, 32'd2);
      wbRead(A_STATUS, rd);
      checkOutput("stopStatus", rd, 32'h0100);

      $display("[TB] LEN saturation and done alongside run");
      coreEnable = 1'b0;
      doneCnt = 0;
      done = 1'b0;
      applyStimulus(A_LEN, 32'd0, 4'hF);
      wbRead(A_LEN, rd);
      checkOutput("lenZeroSat", rd, 32'd16);
      applyStimulus(A_LEN, 32'd20, 4'hF);
      wbRead(A_LEN, rd);
      checkOutput("lenHighSat", rd, 32'd16);
      applyStimulus(A_LEN, 32'd1, 4'hF);
      wbRead(A_LEN, rd);
      checkOutput("len1", rd, 32'd1);
      clearMonitor();
      applyStimulus(A_CTRL, 32'h1, 4'hF);
      @(posedge clk);
      #1;
      checkOutput("len1Run", {31'b0, run}, 32'h1);
      done = 1'b1;
      @(posedge clk);
      #1;
      done = 1'b0;
      checkOutput("earlyDoneBusy", {31'b0, busy}, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("earlyDoneStillWait", {31'b0, busy}, 32'h1);
      checkOutput("earlyDoneNoIrq", irqCount, 32'h0);
      done = 1'b1;
      @(posedge clk);
      #1;
      done = 1'b0;
      checkOutput("len1Irq", {31'b0, irq}, 32'h1);
      checkOutput("len1Idle", {31'b0, busy}, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("len1IrqPulse", {31'b0, irq}, 32'h0);
      checkOutput("len1Runs", runCount, 32'd1);
      wbRead(A_STATUS, rd);
      checkOutput("len1Status", rd, 32'h0002);

      $display("[TB] reset during WAIT");
      applyStimulus(A_LEN, 32'd3, 4'hF);
      applyStimulus(A_CTRL, 32'h1, 4'hF);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("preResetBusy", {31'b0, busy}, 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("midRstBusy", {31'b0, busy}, 32'h0);
      checkOutput("midRstPc", {28'b0, pc}, 32'h0);
      checkOutput("midRstInstr", {16'b0, instr}, 32'h0);
      clearMonitor();
      done = 1'b1;
      @(posedge clk);
      #1;
      done = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("midRstNoRun", runCount, 32'h0);
      checkOutput("midRstNoIrq", irqCount, 32'h0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
